// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16 -- 8N1 UART receiver driven by a 16x oversample strobe.
//
// Purpose:
//   Recovers bytes from the asynchronous serial line rx. The 16x baud square
//   wave from the clock divider (clk_uart) is treated as data: it is registered
//   once on clk_50m and its rising edge becomes a one-cycle tick. All sequencing
//   advances only on tick cycles, so holding clk_uart constant freezes the FSM.
//   Good bytes are presented on rx_data with a one-cycle rx_valid pulse; a low
//   stop bit gives a one-cycle frame_err pulse and the receiver then waits for
//   the line to return high before hunting for a new start bit.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   Inserts an even-parity bit between the data bits and the stop bit. A bad
//   parity bit gives a one-cycle parity_err pulse and suppresses rx_valid for
//   that frame. Without the macro parity_err is constant 0.
//
// Ports:
//   clk_50m    in   1          system clock, the only clock
//   rst_n      in   1          synchronous active-low reset
//   clk_uart   in   1          16x baud square wave, sampled as data
//   rx         in   1          asynchronous serial line, idle high
//   rx_data    out  DATA_BITS  last good byte, held until the next good frame
//   rx_valid   out  1          one-cycle pulse when rx_data updates
//   frame_err  out  1          one-cycle pulse when the stop bit is low
//   parity_err out  1          one-cycle parity failure pulse
//   busy       out  1          high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clk_uart,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int BITN_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // START checks the line half a bit after the falling edge was first seen;
  // every later sample is one full bit period after the previous one.
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_BITS - 1);
  localparam logic [BITN_W-1:0] BITN_ZERO = {BITN_W{1'b0}};
  localparam logic [BITN_W-1:0] BITN_ONE  = BITN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_STOP       = 3'd3,
    S_BREAK_WAIT = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY   = 3'd5
`endif
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic f_even_parity_bad(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit);
    return (^data) ^ par_bit;
  endfunction
`endif

  // Registers
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_cu_q;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BITN_W-1:0]    r_bitn;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  // Next-state wires
  logic                 w_tick;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BITN_W-1:0]    w_bitn_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_frame_err_nxt;

`ifdef UART_RX_PARITY_EN
  logic                 r_parity_err;
  logic                 r_par_bad;
  logic                 w_parity_err_nxt;
  logic                 w_par_bad_nxt;
`endif

  // Rising edge of the oversample wave, one clk_50m cycle wide.
  assign w_tick = clk_uart & ~r_cu_q;

  // Next-state, counter, shift register and output pulse logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bitn_nxt      = r_bitn;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_err_nxt = 1'b0;
    w_par_bad_nxt    = r_par_bad;
`endif

    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
            w_par_bad_nxt = 1'b0;
`endif
          end else begin
            w_state_nxt = S_IDLE;
          end
        end

        S_START: begin
          if (r_cnt == CNT_MID) begin
            if (!r_rx_s) begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = CNT_ZERO;
              w_bitn_nxt  = BITN_ZERO;
            end else begin
              // Start bit did not last half a bit: treat as a glitch.
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = CNT_ZERO;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            // LSB first: shift right so the first bit ends up in bit 0.
            w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_cnt_nxt   = CNT_ZERO;
            w_bitn_nxt  = r_bitn + BITN_ONE;
            if (r_bitn == BITN_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_state_nxt = S_DATA;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = S_STOP;
            if (f_even_parity_bad(r_shift, r_rx_s)) begin
              w_parity_err_nxt = 1'b1;
              w_par_bad_nxt    = 1'b1;
            end else begin
              w_par_bad_nxt    = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = CNT_ZERO;
            if (r_rx_s) begin
              w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!r_par_bad) begin
                w_rx_data_nxt  = r_shift;
                w_rx_valid_nxt = 1'b1;
              end else begin
                w_rx_valid_nxt = 1'b0;
              end
`else
              w_rx_data_nxt  = r_shift;
              w_rx_valid_nxt = 1'b1;
`endif
            end else begin
              // Low stop bit: report once, then wait for the line to recover
              // so a held-low line cannot retrigger a new frame.
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_BREAK_WAIT;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        S_BREAK_WAIT: begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BREAK_WAIT;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      // No tick: everything holds; pulses fall back to their defaults.
      w_state_nxt = r_state;
    end
  end

  // Input conditioning: rx synchroniser and oversample edge register.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_cu_q    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_cu_q    <= clk_uart;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_bitn      <= BITN_ZERO;
      r_shift     <= {DATA_BITS{1'b0}};
      r_rx_data   <= {DATA_BITS{1'b0}};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bitn      <= w_bitn_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      // Registered from the next state so busy tracks r_state exactly.
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse and per-frame parity verdict.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err_nxt;
      r_par_bad    <= w_par_bad_nxt;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16 -- directed self-checking bench for uart_rx_os16.
//
// The oversample wave runs at a shortened period (CU_PERIOD clk_50m cycles
// instead of 326) so the whole run stays short; the receiver only counts
// ticks, so frame timing in ticks is unchanged. Build with UART_RX_PARITY_EN
// defined to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

  localparam int CU_PERIOD = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 176;
`else
  localparam int FRAME_TICKS = 160;
`endif

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clk_uart = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc      = 0;
  int cu_cnt   = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] valid_data [0:15];
  int         valid_cyc  [0:15];

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_os16 #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .clk_uart  (clk_uart),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #10 clk_50m = ~clk_50m;

  // Divider model: square wave changing just after a clk_50m rising edge.
  always @(posedge clk_50m) begin
    cyc = cyc + 1;
    #1;
    cu_cnt   = (cu_cnt == CU_PERIOD - 1) ? 0 : cu_cnt + 1;
    clk_uart = (cu_cnt < CU_PERIOD / 2);
  end

  // Pulse monitor on the falling edge; a pulse longer than one cycle counts twice.
  always @(negedge clk_50m) begin
    if (rx_valid) begin
      if (valid_cnt < 16) begin
        valid_data[valid_cnt] = rx_data;
        valid_cyc[valid_cnt]  = cyc;
      end
      valid_cnt = valid_cnt + 1;
    end
    if (frame_err)  ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk_uart);
  endtask

  // Drives one frame; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_ticks(16);
`endif
    rx = stop_b;
    wait_ticks(16);
  endtask

  initial begin
    logic [7:0] d81;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    check_eq("rst_rx_data",   {24'd0, rx_data}, 32'h0);
    check_eq("rst_rx_valid",  {31'd0, rx_valid}, 32'h0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'h0);
    check_eq("rst_parity_err",{31'd0, parity_err}, 32'h0);
    check_eq("rst_busy",      {31'd0, busy}, 32'h0);
    @(posedge clk_50m);
    #1 rst_n = 1'b1;
    wait_ticks(4);

    // Single byte 0x55
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    @(negedge clk_50m);
    check_eq("b55_valid_cnt", valid_cnt, 32'd1);
    check_eq("b55_data",      {24'd0, valid_data[0]}, 32'h55);
    check_eq("b55_rx_data",   {24'd0, rx_data}, 32'h55);
    check_eq("b55_ferr_cnt",  ferr_cnt, 32'd0);
    check_eq("b55_busy",      {31'd0, busy}, 32'h0);

    // Back-to-back 0xA3, 0x0F
    wait_ticks(5);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    @(negedge clk_50m);
    check_eq("b2b_valid_cnt", valid_cnt, 32'd3);
    check_eq("b2b_data0",     {24'd0, valid_data[1]}, 32'hA3);
    check_eq("b2b_data1",     {24'd0, valid_data[2]}, 32'h0F);
    check_eq("b2b_spacing",   valid_cyc[2] - valid_cyc[1], FRAME_TICKS * CU_PERIOD);
    check_eq("b2b_busy",      {31'd0, busy}, 32'h0);

    // Start glitch: low for 3 ticks, aborted at the half-bit check
    wait_ticks(5);
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    @(negedge clk_50m);
    check_eq("gl_busy_rise",  {31'd0, busy}, 32'h1);
    wait_ticks(6);
    @(negedge clk_50m);
    check_eq("gl_busy_t0p7",  {31'd0, busy}, 32'h1);
    wait_ticks(1);
    @(negedge clk_50m);
    check_eq("gl_busy_t0p8",  {31'd0, busy}, 32'h0);
    check_eq("gl_valid_cnt",  valid_cnt, 32'd3);
    check_eq("gl_ferr_cnt",   ferr_cnt, 32'd0);

    // Framing error: 0x3C with low stop bit, line stays low a little longer
    wait_ticks(5);
    send_frame(8'h3C, 1'b0);
    wait_ticks(4);
    @(negedge clk_50m);
    check_eq("fe_ferr_cnt",   ferr_cnt, 32'd1);
    check_eq("fe_valid_cnt",  valid_cnt, 32'd3);
    check_eq("fe_rx_data",    {24'd0, rx_data}, 32'h0F);
    check_eq("fe_busy_low",   {31'd0, busy}, 32'h1);
    rx = 1'b1;
    wait_ticks(3);
    @(negedge clk_50m);
    check_eq("fe_busy_idle",  {31'd0, busy}, 32'h0);

    // Break: line held low for 5 frame times
    wait_ticks(5);
    rx = 1'b0;
    wait_ticks(5 * FRAME_TICKS);
    @(negedge clk_50m);
    check_eq("brk_ferr_cnt",  ferr_cnt, 32'd2);
    check_eq("brk_valid_cnt", valid_cnt, 32'd3);
    check_eq("brk_busy",      {31'd0, busy}, 32'h1);
    rx = 1'b1;
    wait_ticks(3);
    @(negedge clk_50m);
    check_eq("brk_busy_idle", {31'd0, busy}, 32'h0);

    // Reset during data bit 4 of 0x81
    wait_ticks(5);
    d81 = 8'h81;
    rx  = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < 4; k++) begin
      rx = d81[k];
      wait_ticks(16);
    end
    rx = d81[4];
    wait_ticks(8);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(posedge clk_50m);
    #1 rst_n = 1'b1;
    @(negedge clk_50m);
    check_eq("mr_rx_data",    {24'd0, rx_data}, 32'h0);
    check_eq("mr_busy",       {31'd0, busy}, 32'h0);
    check_eq("mr_rx_valid",   {31'd0, rx_valid}, 32'h0);
    check_eq("mr_frame_err",  {31'd0, frame_err}, 32'h0);
    check_eq("mr_valid_cnt",  valid_cnt, 32'd3);
    check_eq("mr_ferr_cnt",   ferr_cnt, 32'd2);
    wait_ticks(20);

    // Follow-up frame 0x7E
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
`endif
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    @(negedge clk_50m);
`ifdef UART_RX_PARITY_EN
    check_eq("p7e_perr_cnt",  perr_cnt, 32'd1);
    check_eq("p7e_valid_cnt", valid_cnt, 32'd3);
    check_eq("p7e_rx_data",   {24'd0, rx_data}, 32'h0);
`else
    check_eq("b7e_valid_cnt", valid_cnt, 32'd4);
    check_eq("b7e_data",      {24'd0, valid_data[3]}, 32'h7E);
    check_eq("b7e_rx_data",   {24'd0, rx_data}, 32'h7E);
    check_eq("b7e_perr_cnt",  perr_cnt, 32'd0);
`endif
    check_eq("end_ferr_cnt",  ferr_cnt, 32'd2);
    check_eq("end_busy",      {31'd0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 8N1 UART receiver. It sits directly downstream of the clock divider.
- It consumes the divider's 16x-oversample clock (clk_uart, one period = 326 clk_50m cycles) as a data-level input and turns it internally into a one-cycle tick.
- It recovers bytes from the serial rx line and hands them to the frame/command logic as single-cycle valid pulses, with framing-error reporting.
- All logic runs on clk_50m only.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit; the mid-bit sample point is OVERSAMPLE/2.

Ports:
- clk_50m  input  1  system clock, 50 MHz; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- clk_uart  input  1  16x baud square wave from the clock divider; sampled as data.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last good byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle parity failure pulse; tied 0 without the optional feature.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk_50m edge):
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - Internal: state=IDLE, counters=0, synchronisers=1, tick-edge register=0.
  - Reset mid-frame abandons the frame silently; no pulses are emitted.
- Input conditioning:
  - rx passes through a 2-FF synchroniser (reset value 1) to give rx_s.
  - clk_uart is registered once to give cu_q. tick = clk_uart & ~cu_q, one clk_50m cycle wide, once per clk_uart period.
- Counters and sequencing:
  - All state changes happen only on tick cycles, except output pulse clearing.
  - cnt is 4 bits; it never exceeds OVERSAMPLE-1.
  - bitn counts 0..DATA_BITS-1.
- States:
  - IDLE: on tick with rx_s=0, go to START with cnt=0. Call this tick T0.
  - START: on each tick, if cnt==OVERSAMPLE/2-1 then check rx_s; otherwise cnt++. The check happens at T0+8.
    - rx_s=0: go to DATA with cnt=0, bitn=0.
    - rx_s=1: glitch; return to IDLE with no output.
  - DATA: on each tick, if cnt==OVERSAMPLE-1 then sample; otherwise cnt++.
    - Sample: shift right, rx_s into the MSB, cnt=0, bitn++.
    - Data bit k is sampled at T0+24+16k.
    - After bit DATA_BITS-1, go to STOP (or to PARITY with the feature enabled).
  - STOP: same count rule; sample at T0+152 (8 bits, no parity).
    - rx_s=1: rx_data <= shift register; rx_valid=1 for exactly one cycle; go to IDLE.
    - rx_s=0: frame_err=1 for one cycle; rx_data unchanged; go to BREAK_WAIT.
  - BREAK_WAIT: on tick with rx_s=1, go to IDLE. A held-low line yields exactly one frame_err and no retriggering.
- Output timing:
  - Pulses assert on the clk_50m cycle after the sampling tick edge, then deassert the following cycle.
  - There is no back-pressure. A new frame overwrites rx_data; the consumer must capture on rx_valid.
- Edge cases:
  - If clk_uart is held constant, no ticks occur and the FSM freezes in its current state.
  - A new start bit is accepted on the first tick in IDLE after a good stop bit, so back-to-back frames work.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples the even-parity bit at T0+152; stop moves to T0+168.
  - If XOR of data bits and parity bit is 1: parity_err pulses one cycle, rx_valid is suppressed, rx_data is unchanged. The frame still proceeds to STOP for framing checks.
- Undefined:
  - No PARITY state; parity_err is constant 0.

Test Plan:
- Send 0x55 at a bit period of 5216 clk_50m cycles, aligned to clk_uart -> one rx_valid pulse, rx_data=0x55, frame_err=0, busy low after stop.
- Send 0xA3 immediately followed by 0x0F (no idle gap) -> two rx_valid pulses, about 52160 cycles apart, with data 0xA3 then 0x0F.
- rx low pulse of 3 ticks (about 978 cycles) from idle -> busy rises then falls at T0+8, no rx_valid, no frame_err.
- Send 0x3C with the stop bit forced 0, then release rx high -> one frame_err pulse, rx_data keeps its previous value, FSM returns to IDLE once rx is high.
- Hold rx low for 5 frame times -> exactly one frame_err pulse, no further activity until rx goes high.
- Assert rst_n=0 for 2 cycles during data bit 4 of 0x81, then send 0x7E -> all outputs 0 after reset, next rx_valid carries 0x7E. With UART_RX_PARITY_EN, 0x7E sent with parity=1 -> parity_err pulse, no rx_valid.
